// File: rtl/seq_detect_prog_if.sv
// Serial-stream, config and status bundle for the programmable detector.
// The stimulus side uses master; the detector uses slave.
interface seq_detect_prog_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
);
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             en;
    logic             din;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             match;
    logic             match_q;
    logic [CNT_W-1:0] match_cnt;
    logic             cfg_err;

    modport master (
        output en,
        output din,
        output cfg_load,
        output cfg_pattern,
        output cfg_len,
        output cfg_overlap,
        output cnt_clr,
        input  match,
        input  match_q,
        input  match_cnt,
        input  cfg_err
    );

    modport slave (
        input  en,
        input  din,
        input  cfg_load,
        input  cfg_pattern,
        input  cfg_len,
        input  cfg_overlap,
        input  cnt_clr,
        output match,
        output match_q,
        output match_cnt,
        output cfg_err
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector: Mealy match, registered
// match, saturating match counter and rejected-config pulse.
module seq_detect_prog #(
    parameter int               PAT_W       = 8,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(8'b0000_1010),
    parameter int               RST_LEN     = 4,
    parameter bit               RST_OVERLAP = 1'b0
) (
    input logic               clk,
    input logic               reset_n,
    seq_detect_prog_if.slave  bus
);
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             overlap;
    logic [PAT_W-2:0] hist;
    logic [LEN_W-1:0] fill;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] diff;
    logic [LEN_W-1:0] fill_inc;
    logic             fill_ok;
    logic             accept;
    logic             cfg_ok;
    logic             match;
    logic             match_q;
    logic [CNT_W-1:0] cnt;
    logic             cfg_err;

    // Newest len bits of the stream, din included, against pattern[len-1:0].
    always_comb begin
        window = {hist, bus.din};
        mask   = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
        diff     = (window ^ pattern) & mask;
        fill_ok  = ({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, len};
        fill_inc = (fill == LEN_W'(PAT_W)) ? fill
                                           : fill + LEN_W'(1);
        accept   = bus.en & ~bus.cfg_load;
        cfg_ok   = (bus.cfg_len != '0) &&
                   (bus.cfg_len <= LEN_W'(PAT_W));
        match    = reset_n & accept & fill_ok & (diff == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern <= RST_PATTERN;
            len     <= LEN_W'(RST_LEN);
            overlap <= RST_OVERLAP;
            hist    <= '0;
            fill    <= '0;
        end else if (bus.cfg_load) begin
            if (cfg_ok) begin
                pattern <= bus.cfg_pattern;
                len     <= bus.cfg_len;
                overlap <= bus.cfg_overlap;
                hist    <= '0;
                fill    <= '0;
            end
        end else if (bus.en) begin
            hist <= window[PAT_W-2:0];
            // Non-overlap restart: the matched bits never count again.
            fill <= (match && !overlap) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_q <= 1'b0;
            cnt     <= '0;
            cfg_err <= 1'b0;
        end else begin
            match_q <= match;
            cfg_err <= bus.cfg_load & ~cfg_ok;
            if (bus.cnt_clr) begin
                cnt <= '0;
            end else if (match && (cnt != '1)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.match     = match;
    assign bus.match_q   = match_q;
    assign bus.match_cnt = cnt;
    assign bus.cfg_err   = cfg_err;
endmodule

// File: tb/tb_seq_detect_prog.sv
// Random and directed stimulus for seq_detect_prog, checked against a
// queue-based model of the pattern rules; two counter widths in parallel.
module tb_seq_detect_prog;
  localparam int PAT_W = 8;
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int CNT_W = 8;
  localparam int CNT_S = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             en = 1'b0;
  logic             din = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             cnt_clr = 1'b0;

  seq_detect_prog_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus_a ();
  seq_detect_prog_if #(.PAT_W(PAT_W), .CNT_W(CNT_S)) bus_b ();

  assign bus_a.en = en;
  assign bus_a.din = din;
  assign bus_a.cfg_load = cfg_load;
  assign bus_a.cfg_pattern = cfg_pattern;
  assign bus_a.cfg_len = cfg_len;
  assign bus_a.cfg_overlap = cfg_overlap;
  assign bus_a.cnt_clr = cnt_clr;
  assign bus_b.en = en;
  assign bus_b.din = din;
  assign bus_b.cfg_load = cfg_load;
  assign bus_b.cfg_pattern = cfg_pattern;
  assign bus_b.cfg_len = cfg_len;
  assign bus_b.cfg_overlap = cfg_overlap;
  assign bus_b.cnt_clr = cnt_clr;

  seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );
  seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(CNT_S)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [PAT_W-1:0] m_pat;
  int m_len;
  bit m_ovl;
  bit seen[$];
  bit m_mq;
  int m_cnt_a;
  int m_cnt_b;
  bit m_err;
  bit got_m;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pat = PAT_W'(8'b0000_1010);
    m_len = 4;
    m_ovl = 1'b0;
    seen.delete();
    m_mq = 1'b0;
    m_cnt_a = 0;
    m_cnt_b = 0;
    m_err = 1'b0;
  endfunction

  // Bits since the last restart, oldest first, then d, must spell
  // pattern[len-1] .. pattern[0].
  function automatic bit ref_match(input bit d);
    bit b;
    int base;
    if (seen.size() < m_len - 1) return 1'b0;
    base = seen.size() - (m_len - 1);
    for (int i = 0; i < m_len; i++) begin
      b = (i == m_len - 1) ? d : seen[base + i];
      if (b != m_pat[m_len - 1 - i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int sat_inc(input int v, input int w);
    return (v == (1 << w) - 1) ? v : v + 1;
  endfunction

  task automatic cycle(input bit e, input bit d, input bit ld,
                       input logic [PAT_W-1:0] p, input int l,
                       input bit o, input bit clr);
    bit exp_m;
    @(negedge clk);
    en = e;
    din = d;
    cfg_load = ld;
    cfg_pattern = p;
    cfg_len = LEN_W'(l);
    cfg_overlap = o;
    cnt_clr = clr;
    #1;
    exp_m = e && !ld && ref_match(d);
    got_m = bus_a.match;
    chk("match", 32'(bus_a.match), 32'(exp_m));
    chk("match_b", 32'(bus_b.match), 32'(exp_m));
    m_mq = exp_m;
    if (clr) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (exp_m) begin
      m_cnt_a = sat_inc(m_cnt_a, CNT_W);
      m_cnt_b = sat_inc(m_cnt_b, CNT_S);
    end
    m_err = 1'b0;
    if (ld) begin
      if (l >= 1 && l <= PAT_W) begin
        m_pat = p;
        m_len = l;
        m_ovl = o;
        seen.delete();
      end else begin
        m_err = 1'b1;
      end
    end else if (e) begin
      if (exp_m && !m_ovl) begin
        seen.delete();
      end else begin
        seen.push_back(d);
        if (seen.size() > PAT_W) void'(seen.pop_front());
      end
    end
    @(posedge clk);
    #1;
    chk("match_q", 32'(bus_a.match_q), 32'(m_mq));
    chk("match_cnt", 32'(bus_a.match_cnt), 32'(m_cnt_a));
    chk("match_cnt_b", 32'(bus_b.match_cnt), 32'(m_cnt_b));
    chk("cfg_err", 32'(bus_a.cfg_err), 32'(m_err));
  endtask

  task automatic bit_in(input bit d);
    cycle(1'b1, d, 1'b0, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit clr);
    cycle(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, clr);
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input int l,
                      input bit o);
    cycle(1'b1, 1'b1, 1'b1, p, l, o, 1'b0);
  endtask

  // Bit i of bits is the i-th bit sent; obs collects match per bit.
  task automatic stream(input logic [31:0] bits, input int n,
                        output logic [31:0] obs);
    obs = '0;
    for (int i = 0; i < n; i++) begin
      bit_in(bits[i]);
      obs[i] = got_m;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    en = 1'b1;
    din = 1'b0;
    cfg_load = 1'b0;
    cnt_clr = 1'b0;
    model_reset();
    #1;
    chk("rst_match", 32'(bus_a.match), 32'(0));
    chk("rst_match_q", 32'(bus_a.match_q), 32'(0));
    chk("rst_cnt", 32'(bus_a.match_cnt), 32'(0));
    chk("rst_cfg_err", 32'(bus_a.cfg_err), 32'(0));
    @(negedge clk);
    en = 1'b0;
    reset_n = 1'b1;
  endtask

  logic [31:0] obs;
  int l;

  initial begin
    do_reset();

    stream(32'b1010_1010 >> 0 | 32'h0, 0, obs);
    stream(32'b0101_0101, 8, obs);
    chk("plan1_hits", obs, 32'h88);
    chk("plan1_cnt", 32'(bus_a.match_cnt), 32'd2);

    load(8'b1010, 4, 1'b1);
    idle(1'b1);
    stream(32'b0101_0101, 8, obs);
    chk("plan2_hits", obs, 32'hA8);
    chk("plan2_cnt", 32'(bus_a.match_cnt), 32'd3);

    load(8'b111, 3, 1'b1);
    stream(32'h1F, 5, obs);
    chk("ones_ovl", obs, 32'h1C);
    load(8'b111, 3, 1'b0);
    stream(32'h1F, 5, obs);
    chk("ones_novl5", obs, 32'h04);
    load(8'b111, 3, 1'b0);
    stream(32'h3F, 6, obs);
    chk("ones_novl6", obs, 32'h24);

    do_reset();
    stream(32'b101, 3, obs);
    do_reset();
    stream(32'b0, 1, obs);
    chk("post_rst_0", obs, 32'h0);
    stream(32'b0101, 4, obs);
    chk("post_rst_1010", obs, 32'h8);

    do_reset();
    load(8'hFF, 0, 1'b1);
    chk("err_len0", 32'(bus_a.cfg_err), 32'd1);
    idle(1'b0);
    chk("err_clear", 32'(bus_a.cfg_err), 32'd0);
    load(8'hFF, PAT_W + 1, 1'b1);
    chk("err_len9", 32'(bus_a.cfg_err), 32'd1);
    bit_in(1'b1);
    bit_in(1'b0);
    idle(1'b0);
    bit_in(1'b1);
    bit_in(1'b0);
    chk("en_gap_hit", 32'(got_m), 32'd1);

    load(8'b1, 1, 1'b1);
    idle(1'b1);
    stream(32'h3F, 6, obs);
    chk("sat_small", 32'(bus_b.match_cnt), 32'd3);
    chk("cnt_wide", 32'(bus_a.match_cnt), 32'd6);
    cycle(1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1);
    chk("clr_wins", 32'(bus_a.match_cnt), 32'd0);
    chk("clr_wins_b", 32'(bus_b.match_cnt), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 2) begin
        do_reset();
      end else if (r < 12) begin
        if ($urandom_range(0, 4) != 0) l = $urandom_range(1, 4);
        else l = $urandom_range(0, PAT_W + 1);
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'b1, PAT_W'($urandom), l,
              1'($urandom_range(0, 1)), 1'b0);
      end else begin
        cycle(1'($urandom_range(0, 9) != 0),
              1'($urandom_range(0, 1)), 1'b0, PAT_W'($urandom), 0,
              1'b0, 1'($urandom_range(0, 59) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
Programmable serial bit-pattern detector. It is the parametrised successor to the fixed 4-bit Mealy detector. Pattern, pattern length and overlap mode are run-time configurable. A combinational Mealy match, a registered match, a saturating match counter and a config-error flag are provided. It sits on a 1-bit serial input stream inside the serial front-end, one bit per enabled clock.

Parameters:
PAT_W, 8, maximum pattern length in bits (2..16).
CNT_W, 8, match counter width.
RST_PATTERN, 8'b0000_1010, pattern active after reset (LSB-aligned).
RST_LEN, 4, pattern length active after reset.
RST_OVERLAP, 0, overlap mode after reset (0 = non-overlapping, 1 = overlapping).

Ports:
clk  input  1  clock, all state on rising edge.
reset_n  input  1  asynchronous active-low reset.
en  input  1  din valid this cycle.
din  input  1  serial data bit.
cfg_load  input  1  pulse: latch cfg_pattern/cfg_len/cfg_overlap.
cfg_pattern  input  PAT_W  pattern; bit [len-1] is the first bit received, bit [0] the last.
cfg_len  input  $clog2(PAT_W+1)  pattern length, legal range 1..PAT_W.
cfg_overlap  input  1  overlap mode to load.
cnt_clr  input  1  synchronous clear of match_cnt.
match  output  1  Mealy match, combinational from current state and din.
match_q  output  1  match registered, one cycle later.
match_cnt  output  CNT_W  saturating count of matches.
cfg_err  output  1  one-cycle pulse: rejected load.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values while reset_n = 0:
  - pattern = RST_PATTERN, len = RST_LEN, overlap = RST_OVERLAP.
  - hist = 0, fill = 0.
  - match_q = 0, match_cnt = 0, cfg_err = 0.
  - match = 0, forced by gating.
- State:
  - hist: PAT_W-1 bit shift register of past bits, newest bit in [0].
  - fill: 0..PAT_W, bits accepted since the last restart.
- Match equation: match = reset_n & en & ~cfg_load & (fill >= len-1) & ({hist[len-2:0], din} == pattern[len-1:0]).
  - For len = 1, the compare is din == pattern[0].
  - The compare covers len bits only; upper pattern bits are ignored.
- Accepted bit (en = 1, cfg_load = 0):
  - hist <= {hist[PAT_W-3:0], din}.
  - If match and overlap = 0: fill <= 0 (restart; no bit of the matched sequence is reused).
  - Otherwise: fill <= min(fill+1, PAT_W).
- With the reset config (1010, non-overlap), behaviour is cycle-identical to the legacy 1010 detector.
- en = 0: hist, fill and config hold; match = 0.
- cfg_load = 1 has priority over en; din is discarded that cycle.
  - If 1 <= cfg_len <= PAT_W: latch pattern, len and overlap; clear hist and fill.
  - Otherwise: config, hist and fill are unchanged; cfg_err = 1 next cycle.
  - cfg_err is 0 in every cycle not following a rejected load.
- match_q <= match every cycle.
- match_cnt:
  - If cnt_clr: match_cnt <= 0; clear wins over a simultaneous match.
  - Else if match and match_cnt != all-ones: match_cnt <= match_cnt+1.
  - Saturates at 2^CNT_W-1; never wraps.
- Reset mid-stream aborts any partial match. The first post-reset bit starts with fill = 0.
- fill saturates at PAT_W; a long stream never overflows it.
- Latency: match is in the same cycle as the final pattern bit; match_q and match_cnt update 1 cycle later.

Test Plan:
- Reset config, en = 1, din = 1,0,1,0,1,0,1,0 -> match high at bit indices 3 and 7 only; match_cnt = 2; match_q high at cycles 4 and 8.
- cfg_load pattern 1010, len 4, overlap 1; stream 1,0,1,0,1,0,1,0 -> match at indices 3, 5 and 7; match_cnt = 3.
- Load pattern 3'b111, len 3, overlap 1; stream 1,1,1,1,1 -> match at indices 2, 3, 4.
  - Repeat with overlap 0 -> match at index 2 only; with 6 ones, matches at indices 2 and 5.
- Reset config; din 1,0,1 then reset_n low for 1 cycle, then din 0 -> no match; then 1,0,1,0 -> match on the 4th bit.
- cfg_load with cfg_len = 0, then with cfg_len = PAT_W+1:
  - cfg_err pulses one cycle each time.
  - Detection of 1010 continues unchanged.
  - en toggled low mid-pattern (1,0,[en = 0],1,0) -> still matches on the last 0.
- CNT_W = 2, overlap 1, pattern 1 len 1, 6 ones -> match_cnt saturates at 3.
  - cnt_clr asserted in the same cycle as a match -> match_cnt = 0.
